// File: rtl/axi_lite_regbank_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : axi_lite_regbank_pkg
//  Description : State encodings for the register bank read/write FSMs.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_regbank_pkg;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

  typedef enum logic [0:0] {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : axi_pkg
//  Description : Shared AXI response type and encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

endpackage
`default_nettype wire

// File: rtl/axi_lite_if.sv
`default_nettype none
// ============================================================================
//  Interface   : AXI_LITE
//  Description : AXI4-Lite channel bundle with master/slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface AXI_LITE #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32
);
  import axi_pkg::*;

  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic                        aw_valid;
  logic                        aw_ready;
  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_valid;
  logic                        w_ready;
  resp_t                       b_resp;
  logic                        b_valid;
  logic                        b_ready;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic                        ar_valid;
  logic                        ar_ready;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  resp_t                       r_resp;
  logic                        r_valid;
  logic                        r_ready;

  modport Master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

  modport Slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

endinterface
`default_nettype wire

// File: rtl/axi_lite_regbank_cell.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_regbank_cell
//  Description : One register of the bank. Hardware update loads the whole
//                word; a same-cycle bus write overrides the strobed bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_regbank_cell #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      hw_we_i,
  input  logic [DATA_WIDTH-1:0]     hw_wdata_i,
  input  logic                      bus_we_i,
  input  logic [DATA_WIDTH-1:0]     bus_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   bus_strb_i,
  output logic [DATA_WIDTH-1:0]     q_o
);

  logic [DATA_WIDTH-1:0] val_q, val_d;

  // Next value: hold, then hw word load, then strobed bus bytes on top
  always_comb begin
    val_d = val_q;
    if (hw_we_i) begin
      val_d = hw_wdata_i;
    end
    if (bus_we_i) begin
      for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
        if (bus_strb_i[b]) begin
          val_d[b*8 +: 8] = bus_wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Register storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      val_q <= RESET_VAL;
    end else begin
      val_q <= val_d;
    end
  end

  assign q_o = val_q;

endmodule
`default_nettype wire

// File: rtl/axi_lite_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_regbank
//  Description : AXI4-Lite slave register bank with byte-strobed bus writes,
//                per-register write pulses and fabric hardware updates.
//                Optional bus-read-only registers: AXI_LITE_REGBANK_RO_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_regbank
  import axi_pkg::*;
  import axi_lite_regbank_pkg::*;
#(
  parameter int unsigned                    ADDR_WIDTH = 32,
  parameter int unsigned                    DATA_WIDTH = 32,
  parameter int unsigned                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0]          BASE_ADDR  = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [NUM_REGS-1:0]            RO_MASK    = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  AXI_LITE.Slave                         slv,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o,
  input  logic [NUM_REGS-1:0]            hw_we_i,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wdata_i
);

  localparam int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned OFF_BITS = $clog2(STRB_W);

  typedef logic [IDX_W-1:0]      idx_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [STRB_W-1:0]     strb_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  // In range when at/above the base and the word index fits the bank
  function automatic logic addr_ok(input addr_t addr);
    logic  borrow;
    addr_t off;
    {borrow, off} = {1'b0, addr} - {1'b0, BASE_ADDR};
    return !borrow && ((off >> OFF_BITS) < ADDR_WIDTH'(NUM_REGS));
  endfunction

  function automatic idx_t addr_idx(input addr_t addr);
    addr_t off;
    off = addr - BASE_ADDR;
    return off[OFF_BITS +: IDX_W];
  endfunction

  data_t regs_q [NUM_REGS];

  // ---------------- read channel ----------------
  rd_state_e rd_state_q, rd_state_d;
  data_t     r_data_q, r_data_d;
  resp_t     r_resp_q, r_resp_d;
  logic      rd_ok;
  idx_t      rd_idx;

  assign rd_ok  = addr_ok(slv.ar_addr);
  assign rd_idx = addr_idx(slv.ar_addr);

  // Read FSM: capture the addressed register on AR, hold until R handshake
  always_comb begin
    rd_state_d = rd_state_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (slv.ar_valid) begin
          rd_state_d = RD_RESP;
          r_data_d   = rd_ok ? regs_q[rd_idx] : '0;
          r_resp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
      end
      RD_RESP: begin
        if (slv.r_ready) begin
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Read FSM state and response registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_state_q <= RD_IDLE;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
    end
  end

  assign slv.ar_ready = (rd_state_q == RD_IDLE);
  assign slv.r_valid  = (rd_state_q == RD_RESP);
  assign slv.r_data   = r_data_q;
  assign slv.r_resp   = r_resp_q;

  // ---------------- write channel ----------------
  wr_state_e         wr_state_q, wr_state_d;
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  addr_t             aw_addr_q, aw_addr_d;
  data_t             w_data_q, w_data_d;
  strb_t             w_strb_q, w_strb_d;
  resp_t             b_resp_q, b_resp_d;
  logic [NUM_REGS-1:0] pulse_q, pulse_d;

  logic  aw_hs, w_hs, commit, wr_ok, wr_ro;
  addr_t cur_addr;
  data_t cur_data;
  strb_t cur_strb;
  idx_t  wr_idx;

  assign slv.aw_ready = (wr_state_q == WR_IDLE) && !aw_held_q;
  assign slv.w_ready  = (wr_state_q == WR_IDLE) && !w_held_q;
  assign aw_hs        = slv.aw_valid && slv.aw_ready;
  assign w_hs         = slv.w_valid && slv.w_ready;

  // A channel arriving on the commit edge is used directly, bypassing its holding register
  assign cur_addr = aw_held_q ? aw_addr_q : slv.aw_addr;
  assign cur_data = w_held_q  ? w_data_q  : slv.w_data;
  assign cur_strb = w_held_q  ? w_strb_q  : slv.w_strb;
  assign wr_idx   = addr_idx(cur_addr);

`ifdef AXI_LITE_REGBANK_RO_EN
  assign wr_ro = RO_MASK[wr_idx];
`else
  logic unused_ro_mask;
  assign unused_ro_mask = ^RO_MASK;
  assign wr_ro          = 1'b0;
`endif

  assign wr_ok = addr_ok(cur_addr) && !wr_ro;

  // Write FSM: latch AW and W independently, commit once both are present
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    b_resp_d   = b_resp_q;
    pulse_d    = '0;
    commit     = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_addr_d = slv.aw_addr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          w_data_d = slv.w_data;
          w_strb_d = slv.w_strb;
        end
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          commit     = 1'b1;
          wr_state_d = WR_RESP;
          b_resp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
          if (wr_ok) begin
            pulse_d[wr_idx] = 1'b1;
          end
        end
      end
      WR_RESP: begin
        if (slv.b_ready) begin
          wr_state_d = WR_IDLE;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Write FSM state, holding registers, response and pulse registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state_q <= WR_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      b_resp_q   <= RESP_OKAY;
      pulse_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      b_resp_q   <= b_resp_d;
      pulse_q    <= pulse_d;
    end
  end

  assign slv.b_valid = (wr_state_q == WR_RESP);
  assign slv.b_resp  = b_resp_q;
  assign wr_pulse_o  = pulse_q;

  // ---------------- register cells ----------------
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
    logic bus_we;
    assign bus_we = commit && wr_ok && (wr_idx == idx_t'(i));

    axi_lite_regbank_cell #(
      .DATA_WIDTH (DATA_WIDTH),
      .RESET_VAL  (RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH])
    ) u_cell (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .hw_we_i     (hw_we_i[i]),
      .hw_wdata_i  (hw_wdata_i[i*DATA_WIDTH +: DATA_WIDTH]),
      .bus_we_i    (bus_we),
      .bus_wdata_i (cur_data),
      .bus_strb_i  (cur_strb),
      .q_o         (regs_q[i])
    );

    assign reg_q_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

endmodule
`default_nettype wire
